// File: rtl/fpsu_issue_sched.sv
// Issue scheduler for the three-lane FP add/sub unit: writeback slot reservation,
// round-robin arbitration of the shared long path, and per-lane retire tracking.
module fpsu_issue_sched #(
    parameter int LAT_S = 4,
    parameter int LAT_L = 6,
    parameter int TAG_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               u1_req,
    input  logic               u1_long,
    input  logic [20:0]        u1_op,
    input  logic               u1_XSUB,
    input  logic [TAG_W-1:0]   u1_tag,
    output logic               u1_rdy,
    output logic [3:0]         u1_en,
    output logic               u1_sub3,
    input  logic [4:0]         u1_exc,
    output logic [TAG_W+4:0]   u1_ret,
    output logic               u1_ret_en,
    input  logic               u3_req,
    input  logic               u3_long,
    input  logic [20:0]        u3_op,
    input  logic               u3_XSUB,
    input  logic [TAG_W-1:0]   u3_tag,
    output logic               u3_rdy,
    output logic [3:0]         u3_en,
    output logic               u3_sub3,
    input  logic [4:0]         u3_exc,
    output logic [TAG_W+4:0]   u3_ret,
    output logic               u3_ret_en,
    input  logic               u5_req,
    input  logic               u5_long,
    input  logic [20:0]        u5_op,
    input  logic               u5_XSUB,
    input  logic [TAG_W-1:0]   u5_tag,
    output logic               u5_rdy,
    output logic [3:0]         u5_en,
    output logic               u5_sub3,
    input  logic [4:0]         u5_exc,
    output logic [TAG_W+4:0]   u5_ret,
    output logic               u5_ret_en,
    output logic               busy
);

    localparam int NL = 3;

    typedef struct packed {
        logic             v;
        logic [TAG_W-1:0] tag;
    } ent_t;

    logic [NL-1:0]    req, lng, xsub, op10;
    logic [TAG_W-1:0] tag [NL];
    logic [4:0]       exc [NL];
    logic             unused_op;

    assign req  = {u5_req, u3_req, u1_req};
    assign lng  = {u5_long, u3_long, u1_long};
    assign xsub = {u5_XSUB, u3_XSUB, u1_XSUB};
    assign op10 = {u5_op[10], u3_op[10], u1_op[10]};
    assign tag[0] = u1_tag;
    assign tag[1] = u3_tag;
    assign tag[2] = u5_tag;
    assign exc[0] = u1_exc;
    assign exc[1] = u3_exc;
    assign exc[2] = u5_exc;
    assign unused_op = ^{u1_op[20:11], u1_op[9:0], u3_op[20:11], u3_op[9:0],
                         u5_op[20:11], u5_op[9:0]};

    // res_q[i][k] set: lane i writes back k cycles from now.
    // pipe_q[i][k] holds the op whose reservation sits at res index k+1.
    logic [LAT_L:1]   res_q   [NL];
    logic [LAT_L:1]   res_nxt [NL];
    ent_t             pipe_q  [NL][LAT_L-1];
    logic [NL-1:0]    ret_v_q;
    logic [TAG_W-1:0] ret_tag_q [NL];
    logic [3:0]       en_q    [NL];
    logic [2:0]       sub_q   [NL];
    logic [1:0]       rr_q, rr_nxt;
    logic [NL-1:0]    lcand, lgnt, acc;
    logic [1:0]       order [NL];

    always_comb begin
        for (int i = 0; i < NL; i++) begin
            lcand[i] = req[i] & lng[i] & ~flush & ~rst & ~res_q[i][LAT_L];
        end
    end

    // Search order starts at the pointer and wraps 1 -> 3 -> 5 -> 1.
    always_comb begin
        lgnt   = '0;
        rr_nxt = rr_q;
        case (rr_q)
            2'd1:    begin order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd0; end
            2'd2:    begin order[0] = 2'd2; order[1] = 2'd0; order[2] = 2'd1; end
            default: begin order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; end
        endcase
        for (int k = 0; k < NL; k++) begin
            if (lcand[order[k]] && (lgnt == '0)) begin
                lgnt[order[k]] = 1'b1;
                rr_nxt = (order[k] == 2'd2) ? 2'd0 : order[k] + 2'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NL; i++) begin
            acc[i]     = req[i] & ~flush & ~rst &
                         (lng[i] ? lgnt[i] : ~res_q[i][LAT_S]);
            res_nxt[i] = res_q[i] >> 1;
            if (acc[i]) begin
                if (lng[i]) res_nxt[i][LAT_L-1] = 1'b1;
                else        res_nxt[i][LAT_S-1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 2'd0;
        end else begin
            rr_q <= rr_nxt;
        end
        for (int i = 0; i < NL; i++) begin
            if (rst || flush) begin
                res_q[i]     <= '0;
                ret_v_q[i]   <= 1'b0;
                ret_tag_q[i] <= '0;
                en_q[i]      <= 4'h0;
                sub_q[i]     <= 3'b000;
                for (int k = 0; k < LAT_L-1; k++) pipe_q[i][k] <= '0;
            end else begin
                res_q[i]     <= res_nxt[i];
                ret_v_q[i]   <= pipe_q[i][0].v;
                ret_tag_q[i] <= pipe_q[i][0].tag;
                en_q[i]      <= {4{acc[i]}};
                sub_q[i]     <= {sub_q[i][1:0], acc[i] & op10[i] & ~xsub[i]};
                for (int k = 0; k < LAT_L-2; k++) pipe_q[i][k] <= pipe_q[i][k+1];
                pipe_q[i][LAT_L-2] <= '0;
                if (acc[i]) begin
                    if (lng[i]) pipe_q[i][LAT_L-2] <= '{v: 1'b1, tag: tag[i]};
                    else        pipe_q[i][LAT_S-2] <= '{v: 1'b1, tag: tag[i]};
                end
            end
        end
    end

    for (genvar g = 0; g < NL; g++) begin : g_slot_chk
        a_no_slot_collision: assert property (@(posedge clk) disable iff (rst)
            acc[g] |-> !(lng[g] ? res_q[g][LAT_L] : res_q[g][LAT_S]));
    end

    assign u1_rdy    = acc[0];
    assign u3_rdy    = acc[1];
    assign u5_rdy    = acc[2];
    assign u1_en     = en_q[0];
    assign u3_en     = en_q[1];
    assign u5_en     = en_q[2];
    assign u1_sub3   = sub_q[0][2];
    assign u3_sub3   = sub_q[1][2];
    assign u5_sub3   = sub_q[2][2];
    assign u1_ret_en = ret_v_q[0];
    assign u3_ret_en = ret_v_q[1];
    assign u5_ret_en = ret_v_q[2];
    // Exception flags arrive in the writeback cycle itself, so they bypass the register.
    assign u1_ret    = ret_v_q[0] ? {ret_tag_q[0], exc[0]} : '0;
    assign u3_ret    = ret_v_q[1] ? {ret_tag_q[1], exc[1]} : '0;
    assign u5_ret    = ret_v_q[2] ? {ret_tag_q[2], exc[2]} : '0;
    assign busy      = |{res_q[0], res_q[1], res_q[2]};

endmodule

// File: tb/tb_fpsu_issue_sched.sv
// Directed self-checking bench for fpsu_issue_sched (default parameters).
module tb_fpsu_issue_sched;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [2:0]  req, lng, xsub, rdy, sub3, ret_en;
    logic [20:0] op  [3];
    logic [8:0]  tag [3];
    logic [4:0]  exc [3];
    logic [3:0]  en  [3];
    logic [13:0] ret [3];
    logic        busy;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    fpsu_issue_sched dut (
        .clk(clk), .rst(rst), .flush(flush),
        .u1_req(req[0]), .u1_long(lng[0]), .u1_op(op[0]), .u1_XSUB(xsub[0]), .u1_tag(tag[0]),
        .u1_rdy(rdy[0]), .u1_en(en[0]), .u1_sub3(sub3[0]), .u1_exc(exc[0]), .u1_ret(ret[0]),
        .u1_ret_en(ret_en[0]),
        .u3_req(req[1]), .u3_long(lng[1]), .u3_op(op[1]), .u3_XSUB(xsub[1]), .u3_tag(tag[1]),
        .u3_rdy(rdy[1]), .u3_en(en[1]), .u3_sub3(sub3[1]), .u3_exc(exc[1]), .u3_ret(ret[1]),
        .u3_ret_en(ret_en[1]),
        .u5_req(req[2]), .u5_long(lng[2]), .u5_op(op[2]), .u5_XSUB(xsub[2]), .u5_tag(tag[2]),
        .u5_rdy(rdy[2]), .u5_en(en[2]), .u5_sub3(sub3[2]), .u5_exc(exc[2]), .u5_ret(ret[2]),
        .u5_ret_en(ret_en[2]),
        .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0;
        req   = '0;
        lng   = '0;
        xsub  = '0;
        for (int i = 0; i < 3; i++) begin
            op[i]  = '0;
            tag[i] = '0;
            exc[i] = '0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    logic [2:0] exp3;

    initial begin
        rst = 1'b1;
        idle_inputs();

        // reset state
        do_reset();
        check("rst_ret_en", ret_en, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_en1", en[0], 4'h0);
        check("rst_sub3", sub3, 3'b000);
        check("rst_rdy", rdy, 3'b000);
        check("rst_ret1", ret[0], 14'h0);

        // u1 short every cycle, tags 0..15
        for (int c = 0; c < 22; c++) begin
            req[0] = (c < 16);
            tag[0] = 9'(c);
            exc[0] = 5'(c * 7 + 3);
            #1;
            if (c < 16) check("stream_rdy", rdy[0], 1'b1);
            check("stream_ret_en", ret_en[0], (c >= 4 && c < 20));
            check("stream_en", en[0], (c >= 1 && c <= 16) ? 4'hF : 4'h0);
            if (c >= 4 && c < 20) check("stream_ret", ret[0], {9'(c - 4), 5'(c * 7 + 3)});
            else                  check("stream_ret_zero", ret[0], 14'h0);
            tick();
        end

        // long tag 7 then colliding short tag 8
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req[0] = (c == 0 || c == 2 || c == 3);
            lng[0] = (c == 0);
            tag[0] = (c == 0) ? 9'd7 : 9'd8;
            exc[0] = 5'h0B;
            #1;
            if (c == 0) check("coll_long_rdy", rdy[0], 1'b1);
            if (c == 2) check("coll_short_refused", rdy[0], 1'b0);
            if (c == 3) check("coll_short_retry", rdy[0], 1'b1);
            check("coll_ret_en", ret_en[0], (c == 6 || c == 7));
            if (c == 6) check("coll_ret_tag7", ret[0], {9'd7, 5'h0B});
            if (c == 7) check("coll_ret_tag8", ret[0], {9'd8, 5'h0B});
            tick();
            idle_inputs();
        end

        // all lanes long every cycle: round robin 1,3,5
        do_reset();
        for (int c = 0; c < 20; c++) begin
            req = (c < 12) ? 3'b111 : 3'b000;
            lng = 3'b111;
            for (int i = 0; i < 3; i++) tag[i] = 9'(c);
            #1;
            if (c < 12) begin
                exp3 = 3'b001 << (c % 3);
                check("rr_grant", rdy, exp3);
            end
            exp3 = (c >= 6 && c < 18) ? (3'b001 << ((c - 6) % 3)) : 3'b000;
            check("rr_ret_en", ret_en, exp3);
            if (c >= 6 && c < 18) check("rr_ret_tag", ret[(c - 6) % 3], {9'(c - 6), 5'h00});
            tick();
        end

        // stage-3 subtract strobe on u3
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req[1]  = (c == 0 || c == 4 || c == 5);
            op[1]   = (c == 5) ? 21'h0 : 21'h400;
            xsub[1] = (c == 4);
            #1;
            check("sub3", sub3, (c == 3) ? 3'b010 : 3'b000);
            tick();
            idle_inputs();
        end

        // flush kills in-flight ops, refuses same-cycle request
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req[0] = (c <= 4);
            tag[0] = (c == 4) ? 9'h055 : 9'(c);
            flush  = (c == 3);
            exc[0] = 5'h11;
            #1;
            if (c == 3) check("flush_refuse", rdy[0], 1'b0);
            if (c == 3) check("flush_busy_before", busy, 1'b1);
            if (c == 4) check("flush_busy_after", busy, 1'b0);
            if (c == 4) check("flush_new_rdy", rdy[0], 1'b1);
            check("flush_ret_en", ret_en[0], (c == 8));
            if (c == 8) check("flush_ret", ret[0], {9'h055, 5'h11});
            tick();
            idle_inputs();
        end

        // reset with five ops in flight, RR pointer away from lane 1
        do_reset();
        req = 3'b011; lng = 3'b001;
        #1;
        check("mrst_c0_rdy", rdy, 3'b011);
        tick();
        req = 3'b110; lng = 3'b000;
        #1;
        check("mrst_c1_rdy", rdy, 3'b110);
        tick();
        req = 3'b100;
        #1;
        check("mrst_c2_rdy", rdy, 3'b100);
        tick();
        idle_inputs();
        rst = 1'b1;
        #1;
        check("mrst_busy_before", busy, 1'b1);
        tick();
        check("mrst_ret_en", ret_en, 3'b000);
        check("mrst_busy", busy, 1'b0);
        check("mrst_en3", en[1], 4'h0);
        check("mrst_en5", en[2], 4'h0);
        check("mrst_ret3", ret[1], 14'h0);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("mrst_no_stale", ret_en, 3'b000);
            tick();
        end
        req = 3'b111; lng = 3'b111;
        #1;
        check("mrst_rr_lane1", rdy, 3'b001);
        tick();
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
